shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_core.sv | 36 +++
 rtl/shift_arbiter.sv | 105 ++++++++++
 tb/tb_shift_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg -- shared types and constants for the shift arbiter.
//   NUM_REQ     : number of requesters sharing the shifter (2)
//   shift_op_t  : shift operation encoding (SLL, SRL, SRA, ROL)
//   arb_state_t : result-register occupancy (EMPTY, FULL)
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/shift_core.sv
// ---------------------------------------------------------------------------
// shift_core -- combinational N-bit shifter shared by all requesters.
//   op : shift operation (shift_op_t)
//   a  : operand, N bits
//   b  : shift amount, K bits
//   r  : result, N bits (b = 0 returns a for every op)
// ---------------------------------------------------------------------------
module shift_core
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = $clog2(N)
) (
  input  shift_op_t      op,
  input  logic [N-1:0]   a,
  input  logic [K-1:0]   b,
  output logic [N-1:0]   r
);

  // N - b needs one more bit than b; for b = 0 it equals N, so the
  // right-shift term of the rotate vanishes and ROL returns a unchanged.
  logic [K:0] rot_back;

  always_comb begin
    rot_back = (K+1)'(N) - {1'b0, b};
    r        = a;
    case (op)
      OP_SLL:  r = a << b;
      OP_SRL:  r = a >> b;
      OP_SRA:  r = $unsigned($signed(a) >>> b);
      OP_ROL:  r = (a << b) | (a >> rot_back);
      default: r = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter -- two requesters share one shifter through a round-robin
// arbiter feeding a one-entry result register (EMPTY/FULL).
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [1:0] request pending per requester
//   req_ready  : [1:0] request accepted this cycle (one-hot or zero)
//   req_op     : [1:0][1:0] op per requester (00 SLL, 01 SRL, 10 SRA, 11 ROL)
//   req_a      : [1:0][N-1:0] operand per requester
//   req_b      : [1:0][K-1:0] shift amount per requester
//   rsp_valid  : result register holds a valid result
//   rsp_ready  : consumer takes the result this cycle
//   rsp_id     : requester index owning rsp_data
//   rsp_data   : registered shift result
//   gnt_cnt    : [1:0][15:0] saturating accepted-transfer counters
//                (present only when SHIFT_ARB_CNT_EN is defined)
// ---------------------------------------------------------------------------
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][1:0]       req_op,
  input  logic [NUM_REQ-1:0][N-1:0]     req_a,
  input  logic [NUM_REQ-1:0][K-1:0]     req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [N-1:0]                  rsp_data
`ifdef SHIFT_ARB_CNT_EN
  ,
  output logic [NUM_REQ-1:0][15:0]      gnt_cnt
`endif
);

  arb_state_t   state;
  logic         rr_last;
  logic         slot_free;
  logic         gnt_idx;
  logic         transfer;
  logic [N-1:0] core_r;

  always_comb begin
    slot_free = (state == EMPTY) | rsp_ready;
    // On a tie the requester that did not win last time goes next; with a
    // single valid requester it simply wins.
    gnt_idx   = (&req_valid) ? ~rr_last : req_valid[1];
    // rst_n gates the handshake so nothing is accepted while held in reset.
    transfer  = rst_n & slot_free & (|req_valid);
    req_ready = '0;
    if (transfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  shift_core #(
    .N (N),
    .K (K)
  ) u_core (
    .op (shift_op_t'(req_op[gnt_idx])),
    .a  (req_a[gnt_idx]),
    .b  (req_b[gnt_idx]),
    .r  (core_r)
  );

  // Result register FSM. A transfer always wins over a drain, which gives
  // back-to-back throughput when the consumer drains every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rr_last  <= 1'b1;
    end else if (transfer) begin
      state    <= FULL;
      rsp_id   <= gnt_idx;
      rsp_data <= core_r;
      rr_last  <= gnt_idx;
    end else if (rsp_ready) begin
      state    <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

`ifdef SHIFT_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (gnt_cnt[i] != 16'hFFFF)) begin
          gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter -- directed stimulus with a transaction-level reference
// model and a per-cycle comparator, plus hand-computed literal expectations.
// Counter saturation is exercised when SHIFT_ARB_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int N = 32;
  localparam int K = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][1:0]      req_op;
  logic [1:0][N-1:0]    req_a;
  logic [1:0][K-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [N-1:0]         rsp_data;
`ifdef SHIFT_ARB_CNT_EN
  logic [1:0][15:0]     gnt_cnt;
`endif

  int checks = 0;
  int passes = 0;
  bit quiet  = 1'b0;

  shift_arbiter #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef SHIFT_ARB_CNT_EN
    ,
    .gnt_cnt   (gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned p  = 64'd1 << b;
    longint          sa;
    longint          q;
    logic [31:0]     r;
    case (op)
      2'b00: begin
        ua = (ua * p) % 64'h1_0000_0000;
        r  = 32'(ua);
      end
      2'b01: r = 32'(ua / p);
      2'b10: begin
        sa = longint'($signed(a));
        // floor division, so negative operands round toward minus infinity
        if (sa < 0) q = (sa - longint'(p) + 1) / longint'(p);
        else        q = sa / longint'(p);
        r = 32'(q);
      end
      default: begin
        for (int i = 0; i < int'(b); i++) begin
          ua = ua * 2;
          if (ua >= 64'h1_0000_0000) ua = ua - 64'h1_0000_0000 + 1;
        end
        r = 32'(ua);
      end
    endcase
    return r;
  endfunction

  function automatic logic exp_gnt(input logic [1:0] v, input logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return (last == 1'b0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [1:0] exp_ready(input logic rn, input logic [1:0] v, input logic rr,
                                           input logic full, input logic last);
    if (!rn || v == 2'b00 || (full && !rr)) return 2'b00;
    return exp_gnt(v, last) ? 2'b10 : 2'b01;
  endfunction

  logic        m_full;
  logic        m_id;
  logic        m_last;
  logic [31:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_id   <= 1'b0;
      m_data <= '0;
      m_last <= 1'b1;
    end else if (exp_ready(rst_n, req_valid, rsp_ready, m_full, m_last) != 2'b00) begin
      m_full <= 1'b1;
      m_id   <= exp_gnt(req_valid, m_last);
      m_last <= exp_gnt(req_valid, m_last);
      m_data <= ref_shift(req_op[exp_gnt(req_valid, m_last)], req_a[exp_gnt(req_valid, m_last)],
                          req_b[exp_gnt(req_valid, m_last)]);
      if (!quiet)
        $display("xfer id=%0d op=%0d a=%08h b=%0d", exp_gnt(req_valid, m_last),
                 req_op[exp_gnt(req_valid, m_last)], req_a[exp_gnt(req_valid, m_last)],
                 req_b[exp_gnt(req_valid, m_last)]);
    end else if (rsp_ready) begin
      m_full <= 1'b0;
    end
  end

  // ---------------- per-cycle comparator ----------------
  always @(negedge clk) begin
    check("cmp_req_ready", 64'(req_ready), 64'(exp_ready(rst_n, req_valid, rsp_ready, m_full, m_last)));
    check("cmp_rsp_valid", 64'(rsp_valid), 64'(m_full));
    if (m_full || !rst_n) begin
      check("cmp_rsp_id", 64'(rsp_id), 64'(m_id));
      check("cmp_rsp_data", 64'(rsp_data), 64'(m_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [4:0] b);
    req_valid[i] = v;
    req_op[i]    = op;
    req_a[i]     = a;
    req_b[i]     = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // streaming table: both requesters carry the same row, grants alternate
  logic [1:0]  s_op  [8] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01};
  logic [31:0] s_a   [8] = '{32'h80000000, 32'h80000001, 32'h12345678, 32'h80000000,
                             32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
  logic [4:0]  s_b   [8] = '{5'd0, 5'd1, 5'd0, 5'd31, 5'd31, 5'd31, 5'd30, 5'd0};
  logic [31:0] s_exp [8] = '{32'h80000000, 32'h00000003, 32'h12345678, 32'hFFFFFFFF,
                             32'h80000000, 32'h00000001, 32'h00000001, 32'h12345678};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // single request: ROL 1 by 31
    set_req(0, 1'b1, 2'b11, 32'h00000001, 5'd31);
    at_neg();
    check("single_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    at_neg();
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_id", 64'(rsp_id), 64'd0);
    check("single_data", 64'(rsp_data), 64'h80000000);
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // tie after reset: requester 0 first
    do_reset();
    set_req(0, 1'b1, 2'b00, 32'h00000001, 5'd4);
    set_req(1, 1'b1, 2'b10, 32'h80000000, 5'd4);
    rsp_ready = 1'b1;
    at_neg();
    check("tie_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid[0] = 1'b0;
    at_neg();
    check("tie_data0", 64'(rsp_data), 64'h00000010);
    check("tie_id0", 64'(rsp_id), 64'd0);
    check("tie_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    at_neg();
    check("tie_data1", 64'(rsp_data), 64'hF8000000);
    check("tie_id1", 64'(rsp_id), 64'd1);
    tick();

    // backpressure: hold FULL for 3 cycles, then drain and accept together
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b01, 32'h000000F0, 5'd4);
    tick();
    set_req(1, 1'b1, 2'b00, 32'h00000003, 5'd1);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("bp_ready", 64'(req_ready), 64'h0);
      check("bp_data", 64'(rsp_data), 64'h0000000F);
      tick();
    end
    rsp_ready = 1'b1;
    at_neg();
    check("bp_release_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    at_neg();
    check("bp_next_data", 64'(rsp_data), 64'h00000006);
    check("bp_next_id", 64'(rsp_id), 64'd1);
    tick();

    // streaming: both always valid, consumer always ready
    rsp_ready = 1'b1;
    set_req(0, 1'b1, s_op[0], s_a[0], s_b[0]);
    set_req(1, 1'b1, s_op[0], s_a[0], s_b[0]);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 7) begin
        set_req(0, 1'b1, s_op[k+1], s_a[k+1], s_b[k+1]);
        set_req(1, 1'b1, s_op[k+1], s_a[k+1], s_b[k+1]);
      end else begin
        req_valid = '0;
      end
      at_neg();
      check("stream_valid", 64'(rsp_valid), 64'd1);
      check("stream_id", 64'(rsp_id), 64'(k % 2));
      check("stream_data", 64'(rsp_data), 64'(s_exp[k]));
    end
    tick();

    // reset while FULL
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b00, 32'h00000005, 5'd2);
    set_req(1, 1'b1, 2'b01, 32'h00000050, 5'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_full_valid", 64'(rsp_valid), 64'd0);
    check("rst_full_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    at_neg();
    check("rst_first_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    at_neg();
    check("rst_first_id", 64'(rsp_id), 64'd0);
    check("rst_first_data", 64'(rsp_data), 64'h00000014);
    tick();

`ifdef SHIFT_ARB_CNT_EN
    do_reset();
    at_neg();
    check("cnt_reset", 64'(gnt_cnt[0]), 64'h0);
    tick();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 2'b00, 32'h00000001, 5'd1);
    quiet = 1'b1;
    repeat (65537) tick();
    req_valid = '0;
    quiet = 1'b0;
    at_neg();
    check("cnt_sat0", 64'(gnt_cnt[0]), 64'hFFFF);
    check("cnt_idle1", 64'(gnt_cnt[1]), 64'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
